// File: rtl/mem_arbiter_if.sv
// Bus bundle between the LSU ports, the arbiter and the data-memory channel.
// Consumer buses are packed with consumer i at bits [i*W +: W].
interface mem_arbiter_if #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    logic                               mem_read_valid;
    logic [ADDR_BITS-1:0]               mem_read_address;
    logic                               mem_read_ready;
    logic [DATA_BITS-1:0]               mem_read_data;
    logic                               mem_write_valid;
    logic [ADDR_BITS-1:0]               mem_write_address;
    logic [DATA_BITS-1:0]               mem_write_data;
    logic                               mem_write_ready;

    // Arbiter view: takes LSU requests and memory completions, drives the rest.
    modport slave (
        input  consumer_read_valid, consumer_read_address,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output consumer_read_ready, consumer_read_data, consumer_write_ready,
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data
    );

    // Environment view: LSUs plus the memory model.
    modport master (
        output consumer_read_valid, consumer_read_address,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory channel between NUM_CONSUMERS
// LSU ports. One transaction in flight at a time; every output is registered.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | pick next requester at/after rr_ptr, latch its request
// READ_WAIT  | memory read issued, waiting for mem_read_ready
// WRITE_WAIT | memory write issued, waiting for mem_write_ready
// RELAY      | consumer ready held until the granted valid drops
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CONSUMERS - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELAY      = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [IDX_BITS-1:0]                grant_q, grant_d;
    logic [IDX_BITS-1:0]                rr_ptr_q, rr_ptr_d;
    logic                               is_write_q, is_write_d;

    logic                               mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]               mem_read_address_q, mem_read_address_d;
    logic                               mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]               mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]               mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]           read_ready_q, read_ready_d;
    logic [NUM_CONSUMERS-1:0]           write_ready_q, write_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_q, read_data_d;

    logic [NUM_CONSUMERS-1:0]           request;
    logic                               pick_found;
    logic [IDX_BITS-1:0]                pick_idx;
    logic                               pick_is_read;
    logic                               granted_valid;
    logic [IDX_BITS-1:0]                grant_next;
    int                                 pick_abase;
    int                                 pick_dbase;
    int                                 grant_dbase;

    assign request       = bus.consumer_read_valid | bus.consumer_write_valid;
    assign pick_is_read  = bus.consumer_read_valid[pick_idx];
    assign granted_valid = is_write_q ? bus.consumer_write_valid[grant_q]
                                      : bus.consumer_read_valid[grant_q];
    assign grant_next    = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_BITS'(1);
    assign pick_abase    = int'(pick_idx) * ADDR_BITS;
    assign pick_dbase    = int'(pick_idx) * DATA_BITS;
    assign grant_dbase   = int'(grant_q) * DATA_BITS;

    // First requester at or after rr_ptr, scanning upward with wrap.
    always_comb begin
        int cand;
        logic [IDX_BITS-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand     = (int'(rr_ptr_q) + k) % NUM_CONSUMERS;
            cand_idx = IDX_BITS'(cand);
            if (!pick_found && request[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; memory readies only matter in the matching WAIT state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = pick_is_read ? READ_WAIT : WRITE_WAIT;
                end
            end
            READ_WAIT: begin
                if (bus.mem_read_ready) begin
                    state_d = RELAY;
                end
            end
            WRITE_WAIT: begin
                if (bus.mem_write_ready) begin
                    state_d = RELAY;
                end
            end
            RELAY: begin
                if (!granted_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and arbitration bookkeeping.
    always_comb begin
        grant_d             = grant_q;
        rr_ptr_d            = rr_ptr_q;
        is_write_d          = is_write_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        read_ready_d        = read_ready_q;
        write_ready_d       = write_ready_q;
        read_data_d         = read_data_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    // Read wins when one consumer raises both valids.
                    if (pick_is_read) begin
                        is_write_d         = 1'b0;
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d =
                            bus.consumer_read_address[pick_abase +: ADDR_BITS];
                    end else begin
                        is_write_d          = 1'b1;
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d =
                            bus.consumer_write_address[pick_abase +: ADDR_BITS];
                        mem_write_data_d    =
                            bus.consumer_write_data[pick_dbase +: DATA_BITS];
                    end
                end
            end
            READ_WAIT: begin
                if (bus.mem_read_ready) begin
                    mem_read_valid_d = 1'b0;
                    read_data_d[grant_dbase +: DATA_BITS] = bus.mem_read_data;
                    read_ready_d[grant_q] = 1'b1;
                end
            end
            WRITE_WAIT: begin
                if (bus.mem_write_ready) begin
                    mem_write_valid_d      = 1'b0;
                    write_ready_d[grant_q] = 1'b1;
                end
            end
            RELAY: begin
                // Waiting for valid to drop keeps a slow LSU from being re-serviced.
                if (!granted_valid) begin
                    read_ready_d  = '0;
                    write_ready_d = '0;
                    rr_ptr_d      = grant_next;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q             <= '0;
            rr_ptr_q            <= '0;
            is_write_q          <= 1'b0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            read_ready_q        <= '0;
            write_ready_q       <= '0;
            read_data_q         <= '0;
        end else begin
            grant_q             <= grant_d;
            rr_ptr_q            <= rr_ptr_d;
            is_write_q          <= is_write_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            read_ready_q        <= read_ready_d;
            write_ready_q       <= write_ready_d;
            read_data_q         <= read_data_d;
        end
    end

    assign bus.mem_read_valid       = mem_read_valid_q;
    assign bus.mem_read_address     = mem_read_address_q;
    assign bus.mem_write_valid      = mem_write_valid_q;
    assign bus.mem_write_address    = mem_write_address_q;
    assign bus.mem_write_data       = mem_write_data_q;
    assign bus.consumer_read_ready  = read_ready_q;
    assign bus.consumer_write_ready = write_ready_q;
    assign bus.consumer_read_data   = read_data_q;
endmodule
